// File: rtl/simon_player_if.sv
// Signal bundle between the automatic Simon player and the game.
//
// Key handshake: the player raises one bit of k and holds it until the game
// echoes a colour on nl (nl != 0). The player then drops k to 0. The game
// drops nl to 0 to complete the press. The player never raises a new key
// before nl has returned to 0.
interface simon_player_if;
  logic       go;
  logic [3:0] nl;
  logic       nloss;
  logic       inject_en;
  logic [4:0] inject_round;
  logic       start;
  logic [3:0] k;
  logic       busy;
  logic       won;
  logic       lost;
  logic       err;
  logic [5:0] round;

  // Player side.
  modport master (
    input  go, nl, nloss, inject_en, inject_round,
    output start, k, busy, won, lost, err, round
  );

  // Game / environment side.
  modport slave (
    output go, nl, nloss, inject_en, inject_round,
    input  start, k, busy, won, lost, err, round
  );
endinterface

// File: rtl/simon_player.sv
// Automatic Simon player. It watches the colour sequence the game shows on nl
// and stores it. It then replays the sequence as one-hot key presses on k,
// one round at a time. An optional wrong key can be injected to force a loss.
module simon_player (
  input  logic                  clock,
  input  logic                  reset,
  simon_player_if.master        bus,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_CAPTURE = 3'd2,
    S_PRESS   = 3'd3,
    S_RELEASE = 3'd4,
    S_WON     = 3'd5,
    S_LOST    = 3'd6,
    S_ERR     = 3'd7
  } state_t;

  state_t     state, state_n;
  logic [3:0] prev_nl;
  logic [5:0] round_q, round_n;
  logic [5:0] cap_cnt, cap_n;
  logic [4:0] idx, idx_n;
  logic [7:0] wd, wd_n;
  logic       won_q, won_n, lost_q, lost_n, err_q, err_n;
  logic       start_q, start_n, busy_q, busy_n;
  logic [3:0] k_q, k_n;
  logic [1:0] mem [32];
  logic       mem_we;
  logic [1:0] enc;
  logic [1:0] key_col;
  logic       rise, fall, nl_onehot, in_busy, inject;

  function automatic logic [3:0] onehot(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction

  assign rise      = (prev_nl == 4'd0) && (bus.nl != 4'd0);
  assign fall      = (prev_nl != 4'd0) && (bus.nl == 4'd0);
  assign nl_onehot = (bus.nl != 4'd0) && ((bus.nl & (bus.nl - 4'd1)) == 4'd0);
  assign in_busy   = (state == S_START) || (state == S_CAPTURE) ||
                     (state == S_PRESS) || (state == S_RELEASE);

  // Encode a one-hot colour into its index.
  always_comb begin
    enc = 2'd0;
    unique case (bus.nl)
      4'b0010: enc = 2'd1;
      4'b0100: enc = 2'd2;
      4'b1000: enc = 2'd3;
      default: enc = 2'd0;
    endcase
  end

  // Next-state logic: go first, then loss, watchdog, then per-state moves.
  always_comb begin
    state_n = state;
    round_n = round_q;
    cap_n   = cap_cnt;
    idx_n   = idx;
    won_n   = won_q;
    lost_n  = lost_q;
    err_n   = err_q;
    mem_we  = 1'b0;
    if (bus.go) begin
      state_n = S_START;
      round_n = 6'd0;
      cap_n   = 6'd0;
      idx_n   = 5'd0;
      won_n   = 1'b0;
      lost_n  = 1'b0;
      err_n   = 1'b0;
    end else if (in_busy && bus.nloss) begin
      state_n = S_LOST;
      lost_n  = 1'b1;
    end else if (in_busy && (wd == 8'd255)) begin
      state_n = S_ERR;
      err_n   = 1'b1;
    end else begin
      unique case (state)
        S_START: state_n = S_CAPTURE;
        S_CAPTURE: begin
          if (rise) begin
            if (!nl_onehot || (cap_cnt == 6'd32)) begin
              state_n = S_ERR;
              err_n   = 1'b1;
            end else begin
              mem_we = 1'b1;
              cap_n  = cap_cnt + 6'd1;
            end
          end else if (fall && (cap_cnt == round_q + 6'd1)) begin
            state_n = S_PRESS;
            idx_n   = 5'd0;
          end
        end
        S_PRESS: begin
          if (bus.nl != 4'd0) state_n = S_RELEASE;
        end
        S_RELEASE: begin
          if (bus.nl == 4'd0) begin
            if ({1'b0, idx} < round_q) begin
              idx_n   = idx + 5'd1;
              state_n = S_PRESS;
            end else if (round_q < 6'd31) begin
              round_n = round_q + 6'd1;
              cap_n   = 6'd0;
              state_n = S_CAPTURE;
            end else begin
              round_n = 6'd32;
              won_n   = 1'b1;
              state_n = S_WON;
            end
          end
        end
        default: state_n = state;
      endcase
    end
  end

  // Registered outputs and watchdog, derived from the next state.
  always_comb begin
    inject  = bus.inject_en && (round_n == {1'b0, bus.inject_round}) &&
              ({1'b0, idx_n} == round_n);
    key_col = mem[idx_n] + (inject ? 2'd1 : 2'd0);
    k_n     = (state_n == S_PRESS) ? onehot(key_col) : 4'd0;
    start_n = (state_n == S_START);
    busy_n  = (state_n == S_START) || (state_n == S_CAPTURE) ||
              (state_n == S_PRESS) || (state_n == S_RELEASE);
    wd_n    = wd;
    if (bus.go || (state_n != state) || rise || fall) wd_n = 8'd0;
    else if (in_busy) wd_n = wd + 8'd1;
  end

  // State and control registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      prev_nl <= 4'd0;
      round_q <= 6'd0;
      cap_cnt <= 6'd0;
      idx     <= 5'd0;
      wd      <= 8'd0;
      won_q   <= 1'b0;
      lost_q  <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      k_q     <= 4'd0;
    end else begin
      state   <= state_n;
      prev_nl <= bus.nl;
      round_q <= round_n;
      cap_cnt <= cap_n;
      idx     <= idx_n;
      wd      <= wd_n;
      won_q   <= won_n;
      lost_q  <= lost_n;
      err_q   <= err_n;
      start_q <= start_n;
      busy_q  <= busy_n;
      k_q     <= k_n;
    end
  end

  // Colour memory; contents are meaningless after reset.
  always_ff @(posedge clock) begin
    if (mem_we) mem[cap_cnt[4:0]] <= enc;
  end

  assign bus.start = start_q;
  assign bus.k     = k_q;
  assign bus.busy  = busy_q;
  assign bus.won   = won_q;
  assign bus.lost  = lost_q;
  assign bus.err   = err_q;
  assign bus.round = round_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_simon_player.sv
module tb_simon_player;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_CAPTURE = 3'd2, ST_PRESS = 3'd3,
                         ST_WON = 3'd5, ST_LOST = 3'd6, ST_ERR = 3'd7;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] dbg_state;

  simon_player_if bus();

  simon_player dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 clock = ~clock;

  typedef struct {
    bit         inj_en;
    logic [4:0] inj_round;
    bit         exp_won;
    bit         exp_lost;
    logic [5:0] exp_round;
    logic [2:0] exp_state;
  } vec_t;

  vec_t       vecs[4];
  logic [1:0] seq[32];
  logic [3:0] exp_q[$];
  int         n_checks = 0;
  int         n_errs = 0;
  bit         abort = 0;

  function automatic logic [3:0] key_of(input logic [1:0] c);
    logic [3:0] r;
    case (c)
      2'd0: r = 4'b0001;
      2'd1: r = 4'b0010;
      2'd2: r = 4'b0100;
      default: r = 4'b1000;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic show_colour(input logic [1:0] c);
    bus.nl = key_of(c);
    tick(); tick();
    bus.nl = 4'd0;
    tick(); tick();
  endtask

  task automatic wait_key();
    for (int i = 0; i < 64 && bus.k == 4'd0; i++) tick();
  endtask

  task automatic pulse_go();
    int highs;
    highs = 0;
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    if (bus.start) highs++;
    tick();
    if (bus.start) highs++;
    check("start_pulse_width", highs, 1);
    check("state_after_start", dbg_state, ST_CAPTURE);
    check("busy_after_start", bus.busy, 1);
    check("round_after_start", bus.round, 0);
  endtask

  // Game model: shows rounds, scoreboards keys, echoes or signals loss.
  task automatic run_game(input bit inj_en, input logic [4:0] inj_r);
    bit         done;
    logic [1:0] bad;
    logic [3:0] got;
    done = 0;
    for (int r = 0; r < 32 && !done && !abort; r++) begin
      check("round_at_capture", bus.round, r);
      for (int i = 0; i <= r; i++) begin
        bad = seq[i] + 2'd1;
        if (inj_en && (r == int'(inj_r)) && (i == r)) exp_q.push_back(key_of(bad));
        else exp_q.push_back(key_of(seq[i]));
        show_colour(seq[i]);
      end
      for (int i = 0; i <= r && !done; i++) begin
        wait_key();
        check("key_wait", bus.k != 4'd0, 1);
        if (bus.k == 4'd0) begin
          abort = 1;
          done = 1;
        end else begin
          got = bus.k;
          check("key", got, exp_q.pop_front());
          if (got !== key_of(seq[i])) begin
            bus.nloss = 1'b1;
            tick();
            bus.nloss = 1'b0;
            check("lost_flag", bus.lost, 1);
            check("lost_k_zero", bus.k, 0);
            check("lost_state", dbg_state, ST_LOST);
            done = 1;
          end else begin
            bus.nl = got;
            tick();
            for (int j = 0; j < 16 && bus.k != 4'd0; j++) tick();
            check("key_release", bus.k, 0);
            bus.nl = 4'd0;
            tick();
          end
        end
      end
    end
  endtask

  initial begin
    int cnt;
    reset = 1'b1;
    bus.go = 1'b0;
    bus.nl = 4'd0;
    bus.nloss = 1'b0;
    bus.inject_en = 1'b0;
    bus.inject_round = 5'd0;
    vecs[0] = '{0, 5'd0,  1, 0, 6'd32, ST_WON};
    vecs[1] = '{1, 5'd2,  0, 1, 6'd2,  ST_LOST};
    vecs[2] = '{1, 5'd0,  0, 1, 6'd0,  ST_LOST};
    vecs[3] = '{1, 5'd31, 0, 1, 6'd31, ST_LOST};
    tick(); tick();
    reset = 1'b0;

    check("rst_state", dbg_state, ST_IDLE);
    check("rst_k", bus.k, 0);
    check("rst_start", bus.start, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_flags", {bus.won, bus.lost, bus.err}, 0);
    check("rst_round", bus.round, 0);

    // Table-driven full games
    for (int v = 0; v < 4 && !abort; v++) begin
      for (int i = 0; i < 32; i++) seq[i] = 2'($urandom_range(0, 3));
      seq[0] = 2'd2;
      seq[2] = 2'd3;
      bus.inject_en = vecs[v].inj_en;
      bus.inject_round = vecs[v].inj_round;
      exp_q.delete();
      pulse_go();
      run_game(vecs[v].inj_en, vecs[v].inj_round);
      tick(); tick();
      check("vec_won", bus.won, 32'(vecs[v].exp_won));
      check("vec_lost", bus.lost, 32'(vecs[v].exp_lost));
      check("vec_err", bus.err, 0);
      check("vec_busy", bus.busy, 0);
      check("vec_k", bus.k, 0);
      check("vec_round", bus.round, 32'(vecs[v].exp_round));
      check("vec_state", dbg_state, 32'(vecs[v].exp_state));
      if (!vecs[v].exp_lost) check("vec_queue_empty", exp_q.size(), 0);
    end
    bus.inject_en = 1'b0;
    exp_q.delete();

    // Non-one-hot rise during capture
    pulse_go();
    bus.nl = 4'b0011;
    tick();
    check("bad_colour_err", bus.err, 1);
    check("bad_colour_state", dbg_state, ST_ERR);
    check("bad_colour_k", bus.k, 0);
    bus.nl = 4'd0;
    tick(); tick(); tick();
    check("err_holds", dbg_state, ST_ERR);
    check("err_not_busy", bus.busy, 0);

    // Withheld echo trips the watchdog
    pulse_go();
    show_colour(2'd2);
    wait_key();
    check("wd_key", bus.k, 4'b0100);
    check("wd_state", dbg_state, ST_PRESS);
    cnt = 0;
    for (int i = 0; i < 300 && !bus.err; i++) begin
      tick();
      cnt++;
    end
    check("wd_err", bus.err, 1);
    check("wd_k", bus.k, 0);
    check("wd_latency", (cnt >= 240) && (cnt <= 258), 1);

    // Reset mid-press
    pulse_go();
    show_colour(2'd3);
    wait_key();
    check("mid_key", bus.k, 4'b1000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_k", bus.k, 0);
    check("mid_rst_flags", {bus.won, bus.lost, bus.err, bus.busy, bus.start}, 0);
    check("mid_rst_round", bus.round, 0);
    check("mid_rst_state", dbg_state, ST_IDLE);

    // Reset overrides go
    reset = 1'b1;
    bus.go = 1'b1;
    tick();
    reset = 1'b0;
    bus.go = 1'b0;
    check("rst_over_go_state", dbg_state, ST_IDLE);
    check("rst_over_go_start", bus.start, 0);
    tick();
    pulse_go();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
